// File: rtl/alu_md.sv
// alu_md: EX-stage ALU with registered single-cycle ops and iterative mul/div into HI/LO.
// Optional early multiply exit on exhausted multiplier: define ALU_MD_EARLY_OUT_EN.
module alu_md #(
    parameter int WIDTH = 32,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] busA,
    input  logic [WIDTH-1:0] busB,
    input  logic [SHW-1:0]   s,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] ALUout,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_OR    = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_NOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MULTU = 4'd10;
    localparam logic [3:0] OP_MULT  = 4'd11;
    localparam logic [3:0] OP_DIVU  = 4'd12;
    localparam logic [3:0] OP_DIV   = 4'd13;
    localparam logic [3:0] OP_MFHI  = 4'd14;
    localparam logic [3:0] OP_MFLO  = 4'd15;

    localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DIV,
        FIX
    } state_t;

    state_t state, state_nxt;

    logic [SHW-1:0]     cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   a_raw;
    logic               is_div;
    logic               qneg;
    logic               rneg;
    logic               dzf;

    logic               accept;
    logic               start;
    logic               is_mul_op;
    logic               is_div_op;
    logic               sgn;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   res;
    logic               mul_done;
    logic               mul_skip;

    logic [WIDTH:0]     r2;
    logic               ge;
    logic [WIDTH-1:0]   diff;

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign in_ready  = (state == IDLE);
    assign accept    = in_valid && in_ready;
    assign start     = accept && !flush;
    assign is_mul_op = (op == OP_MULTU) || (op == OP_MULT);
    assign is_div_op = (op == OP_DIVU) || (op == OP_DIV);
    assign sgn       = (op == OP_MULT) || (op == OP_DIV);
    assign mag_a     = (sgn && busA[WIDTH-1]) ? -busA : busA;
    assign mag_b     = (sgn && busB[WIDTH-1]) ? -busB : busB;

`ifdef ALU_MD_EARLY_OUT_EN
    // Stop once no set multiplier bits remain above the one being consumed.
    assign mul_done = (cnt == LAST) || (opb[WIDTH-1:1] == '0);
    assign mul_skip = (mag_b == '0);
`else
    assign mul_done = (cnt == LAST);
    assign mul_skip = 1'b0;
`endif

    // Restoring divide step: partial remainder in acc upper half, dividend bits shift out of lower half.
    assign r2   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    assign ge   = (r2 >= {1'b0, opb});
    assign diff = r2[WIDTH-1:0] - opb;

    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = busA + busB;
            OP_SUB:  res = busA - busB;
            OP_OR:   res = busA | busB;
            OP_AND:  res = busA & busB;
            OP_NOR:  res = ~(busA | busB);
            OP_SLL:  res = busB << s;
            OP_SRL:  res = busB >> s;
            OP_SRA:  res = $signed(busB) >>> s;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, $signed(busA) < $signed(busB)};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, busA < busB};
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    always_comb begin
        prod   = qneg ? -acc : acc;
        quo    = qneg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem    = rneg ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div) begin
            if (dzf) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = rem;
                fix_lo = quo;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start && is_mul_op) begin
                    state_nxt = mul_skip ? FIX : MUL;
                end else if (start && is_div_op) begin
                    state_nxt = DIV;
                end
            end
            MUL: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (mul_done) begin
                    state_nxt = FIX;
                end
            end
            DIV: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST) begin
                    state_nxt = FIX;
                end
            end
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            ALUout    <= '0;
            hi        <= '0;
            lo        <= '0;
            dz        <= 1'b0;
            cnt       <= '0;
            acc       <= '0;
            mcand     <= '0;
            opb       <= '0;
            a_raw     <= '0;
            is_div    <= 1'b0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            dzf       <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cnt <= '0;
                        if (is_mul_op || is_div_op) begin
                            acc    <= is_div_op ? {{WIDTH{1'b0}}, mag_a} : '0;
                            mcand  <= {{WIDTH{1'b0}}, mag_a};
                            opb    <= mag_b;
                            a_raw  <= busA;
                            is_div <= is_div_op;
                            qneg   <= sgn && (busA[WIDTH-1] ^ busB[WIDTH-1]);
                            rneg   <= sgn && busA[WIDTH-1];
                            dzf    <= (busB == '0);
                        end else begin
                            ALUout    <= res;
                            out_valid <= 1'b1;
                            dz        <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc   <= acc + (opb[0] ? mcand : '0);
                    mcand <= mcand << 1;
                    opb   <= opb >> 1;
                    cnt   <= cnt + SHW'(1);
                end
                DIV: begin
                    acc <= {ge ? diff : r2[WIDTH-1:0], acc[WIDTH-2:0], ge};
                    cnt <= cnt + SHW'(1);
                end
                FIX: begin
                    if (!flush) begin
                        hi        <= fix_hi;
                        lo        <= fix_lo;
                        ALUout    <= fix_lo;
                        out_valid <= 1'b1;
                        dz        <= is_div && dzf;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// tb_alu_md: scoreboard bench for alu_md; a reference model pushes expected
// results at issue time and a monitor pops and compares them on out_valid.
module tb_alu_md;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   op;
    logic [W-1:0] busA;
    logic [W-1:0] busB;
    logic [4:0]   s;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] ALUout;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dz;

    alu_md #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .busA      (busA),
        .busB      (busB),
        .s         (s),
        .flush     (flush),
        .out_valid (out_valid),
        .ALUout    (ALUout),
        .hi        (hi),
        .lo        (lo),
        .dz        (dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] alu;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           cyc;
        int           lat;
    } exp_t;

    exp_t         sbq[$];
    exp_t         mon_e;
    int           cyc = 0;
    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] mhi = '0;
    logic [W-1:0] mlo = '0;
    int           last_lat = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] o, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic [4:0] sh,
                                   input logic [W-1:0] h, input logic [W-1:0] l);
        exp_t         e;
        logic [63:0]  p;
        logic [W-1:0] mb;
        int           sa;
        int           sb;
        e.tag = "";
        e.cyc = 0;
        e.hi  = h;
        e.lo  = l;
        e.dz  = 1'b0;
        e.lat = 1;
        e.alu = '0;
        case (o)
            4'd0:  e.alu = a + b;
            4'd1:  e.alu = a - b;
            4'd2:  e.alu = a | b;
            4'd3:  e.alu = a & b;
            4'd4:  e.alu = ~(a | b);
            4'd5:  e.alu = b << sh;
            4'd6:  e.alu = b >> sh;
            4'd7:  e.alu = $signed(b) >>> sh;
            4'd8:  e.alu = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  e.alu = (a < b) ? 32'd1 : 32'd0;
            4'd10, 4'd11: begin
                if (o == 4'd11) p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                else            p = {32'd0, a} * {32'd0, b};
                e.hi  = p[63:32];
                e.lo  = p[31:0];
                e.lat = W + 2;
`ifdef ALU_MD_EARLY_OUT_EN
                mb    = (o == 4'd11 && b[31]) ? -b : b;
                e.lat = 2;
                for (int i = 0; i < W; i++) if (mb[i]) e.lat = 3 + i;
`else
                mb    = b;
`endif
            end
            4'd12, 4'd13: begin
                e.lat = W + 2;
                sa    = a;
                sb    = b;
                if (b == '0) begin
                    e.lo = '1;
                    e.hi = a;
                    e.dz = 1'b1;
                end else if (o == 4'd12) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = '0;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            4'd14: e.alu = h;
            default: e.alu = l;
        endcase
        if (o >= 4'd10 && o <= 4'd13) e.alu = e.lo;
        return e;
    endfunction

    always @(negedge clk) begin
        if (out_valid) begin
            if (sbq.size() == 0) begin
                check("spurious_out_valid", 64'd1, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                check({mon_e.tag, "_alu"}, ALUout, mon_e.alu);
                check({mon_e.tag, "_hi"}, hi, mon_e.hi);
                check({mon_e.tag, "_lo"}, lo, mon_e.lo);
                check({mon_e.tag, "_dz"}, dz, mon_e.dz);
                check({mon_e.tag, "_lat"}, cyc - mon_e.cyc, mon_e.lat);
            end
        end
    end

    task automatic idle();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 200) begin
            in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, in_ready, 1'b1);
        e     = model(o, a, b, sh, mhi, mlo);
        e.tag = tag;
        e.cyc = cyc;
        mhi   = e.hi;
        mlo   = e.lo;
        last_lat = e.lat;
        sbq.push_back(e);
        in_valid = 1'b1;
        op       = o;
        busA     = a;
        busB     = b;
        s        = sh;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 0);
        @(negedge clk);
    endtask

    task automatic count_ov(input string tag, input int ncyc);
        int n = 0;
        for (int i = 0; i < ncyc; i++) begin
            n += int'(out_valid);
            @(negedge clk);
        end
        check(tag, n, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [3:0]   ro;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        op = '0;
        busA = '0;
        busB = '0;
        s = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_alu", ALUout, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", dz, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        issue("add_ovf", 4'd0, 32'h7FFF_FFFF, 32'h1, 5'd0);
        issue("sra", 4'd7, 32'h0, 32'h8000_0000, 5'd4);
        issue("sub", 4'd1, 32'h0, 32'h1, 5'd0);
        issue("or", 4'd2, 32'hF0F0_0000, 32'h0000_0F0F, 5'd0);
        issue("and", 4'd3, 32'hFF00_FF00, 32'h0FF0_0FF0, 5'd0);
        issue("nor", 4'd4, 32'h1234_5678, 32'h0F0F_0F0F, 5'd0);
        issue("sll", 4'd5, 32'h0, 32'h8000_0001, 5'd31);
        issue("srl", 4'd6, 32'h0, 32'h8000_0000, 5'd4);
        issue("slt", 4'd8, 32'hFFFF_FFFF, 32'h1, 5'd0);
        issue("sltu", 4'd9, 32'hFFFF_FFFF, 32'h1, 5'd0);
        drain();

        issue("mult", 4'd11, 32'hFFFF_FFFD, 32'h5, 5'd0);
        idle();
        n = 0;
        while (!in_ready && n < 100) begin
            busA = $urandom;
            busB = $urandom;
            n++;
            @(negedge clk);
        end
        check("mult_busy", n, last_lat - 1);
        issue("mfhi", 4'd14, 32'h0, 32'h0, 5'd0);
        issue("mflo", 4'd15, 32'h0, 32'h0, 5'd0);
        issue("div_neg", 4'd13, 32'hFFFF_FFF9, 32'h2, 5'd0);
        issue("divu", 4'd12, 32'h64, 32'h7, 5'd0);
        issue("divu_dz", 4'd12, 32'h1234, 32'h0, 5'd0);
        issue("div_dz", 4'd13, 32'h8000_0005, 32'h0, 5'd0);
        issue("div_ovf", 4'd13, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0);
        issue("div_negb", 4'd13, 32'h7, 32'hFFFF_FFFE, 5'd0);
        issue("multu_big", 4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
        issue("mult_min", 4'd11, 32'h8000_0000, 32'h8000_0000, 5'd0);
        issue("add_after", 4'd0, 32'h1, 32'h2, 5'd0);
        drain();

        // reset in the middle of a multiply
        in_valid = 1'b1;
        op = 4'd10;
        busA = 32'hDEAD_BEEF;
        busB = 32'hF000_0001;
        @(negedge clk);
        idle();
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", in_ready, 1'b1);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_hi", hi, 0);
        check("mid_rst_lo", lo, 0);
        rst = 1'b0;
        mhi = '0;
        mlo = '0;
        count_ov("mid_rst_no_ov", 40);

        // flush in the middle of a multiply keeps prior HI/LO
        issue("multu_pre", 4'd10, 32'h1234_5678, 32'h9ABC_DEF1, 5'd0);
        drain();
        in_valid = 1'b1;
        op = 4'd10;
        busA = 32'h0BAD_F00D;
        busB = 32'h8000_0003;
        @(negedge clk);
        idle();
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_hi", hi, mhi);
        check("flush_lo", lo, mlo);
        count_ov("flush_no_ov", 40);
        check("flush_hi_kept", hi, mhi);
        check("flush_lo_kept", lo, mlo);

        // flush together with an accept in IDLE
        in_valid = 1'b1;
        flush = 1'b1;
        op = 4'd0;
        busA = 32'h5;
        busB = 32'h6;
        @(negedge clk);
        op = 4'd12;
        @(negedge clk);
        idle();
        check("idle_flush_ready", in_ready, 1'b1);
        count_ov("idle_flush_no_ov", 5);
        issue("mflo_after", 4'd15, 32'h0, 32'h0, 5'd0);
        drain();

        for (int i = 0; i < 24; i++) begin
            ro = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, 31);
            issue($sformatf("rnd%0d", i), ro, ra, rb, 5'($urandom_range(0, 31)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
